// File: rtl/char_stream_pkg.sv
// rtl/char_stream_pkg.sv - shared FSM state encoding and character constants for char_stream_ram
package char_stream_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHOW  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

endpackage

// File: rtl/char_ram.sv
// rtl/char_ram.sv - inferred simple dual-port synchronous RAM, read-first, 1-cycle read latency
module char_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] r_mem [2**ADDR_W];
  logic [WIDTH-1:0] r_rd_data;

  // Read and write share one edge, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/char_stream_ram.sv
// rtl/char_stream_ram.sv - character store with message streaming engine; CHAR_PARITY_EN adds per-char parity
module char_stream_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_par_flip,
  input  logic [ADDR_W-1:0] msg_base,
  input  logic [ADDR_W-1:0] msg_len,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              parity_err
);
  import char_stream_pkg::*;

`ifdef CHAR_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] ONE = 1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr, r_remaining, r_base, r_len;
  logic              r_loop, r_out_valid, r_done;
  logic [DATA_W-1:0] r_out_data;
  logic [RAM_W-1:0]  w_wr_word, w_rd_word;
  logic              w_start_acc;

`ifdef CHAR_PARITY_EN
  assign w_wr_word = {^wr_data ^ wr_par_flip, wr_data};
`else
  logic w_unused_par_flip;
  assign w_unused_par_flip = wr_par_flip;
  assign w_wr_word = wr_data;
`endif

  char_ram #(.WIDTH(RAM_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (w_wr_word),
    .rd_addr (r_ptr),
    .rd_data (w_rd_word)
  );

  assign w_start_acc = start & ~stop & (r_state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_base      <= '0;
      r_len       <= '0;
      r_loop      <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_state     <= IDLE;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (start) begin
            r_base      <= msg_base;
            r_len       <= msg_len;
            r_loop      <= loop_en;
            r_ptr       <= msg_base;
            r_remaining <= msg_len;
            if (msg_len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= FETCH;
            end
          end
          FETCH: r_state <= LOAD;
          LOAD: begin
            r_out_data  <= w_rd_word[DATA_W-1:0];
            r_out_valid <= 1'b1;
            r_state     <= SHOW;
          end
          SHOW: if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_remaining == ONE) begin
              if (r_loop) begin
                r_ptr       <= r_base;
                r_remaining <= r_len;
                r_state     <= FETCH;
              end else begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end else begin
              // Pointer wraps naturally past the top of the array.
              r_ptr       <= r_ptr + ONE;
              r_remaining <= r_remaining - ONE;
              r_state     <= FETCH;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef CHAR_PARITY_EN
  logic r_parity_err;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_parity_err <= 1'b0;
    else if (w_start_acc)      r_parity_err <= 1'b0;
    else if (r_state == LOAD && (w_rd_word[DATA_W] != ^w_rd_word[DATA_W-1:0]))
      r_parity_err <= 1'b1;
  end
  assign parity_err = r_parity_err;
`else
  logic w_unused_start_acc;
  assign w_unused_start_acc = w_start_acc;
  assign parity_err = 1'b0;
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_char_stream_ram.sv
// tb/tb_char_stream_ram.sv - table-driven self-checking bench for char_stream_ram
module tb_char_stream_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, wr_par_flip, loop_en, start, stop, out_ready;
  logic [10:0] wr_addr, msg_base, msg_len;
  logic [7:0]  wr_data, out_data;
  logic        out_valid, busy, done, parity_err;

  int checks = 0;
  int errors = 0;

  char_stream_ram #(.DATA_W(8), .ADDR_W(11)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_par_flip(wr_par_flip), .msg_base(msg_base), .msg_len(msg_len), .loop_en(loop_en),
    .start(start), .stop(stop), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] base;
    logic [10:0] len;
    logic [39:0] exp;
    int          stall_idx;
    int          stall_n;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [10:0] a, input logic [7:0] d, input logic flip);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_par_flip = flip;
    @(negedge clk);
    wr_en = 1'b0; wr_par_flip = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    msg_base = v.base; msg_len = v.len; loop_en = 1'b0; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_in_fetch", out_valid, 0);
    @(negedge clk);
    for (int k = 0; k < int'(v.len); k++) begin
      if (k > 0) repeat (2) @(negedge clk);
      @(negedge clk);
      check("char_valid", out_valid, 1);
      check("char_data", out_data, v.exp[8*k +: 8]);
      if (k == v.stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < v.stall_n; s++) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, v.exp[8*k +: 8]);
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("valid_after_last", out_valid, 0);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("busy_cleared", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{11'h040, 11'd5, 40'h797272654D, -1, 0};
    vecs[1] = '{11'h040, 11'd5, 40'h797272654D, 1, 4};
    vecs[2] = '{11'h7FE, 11'd4, 40'h005A595857, -1, 0};
    vecs[3] = '{11'h7FF, 11'd2, 40'h0000005958, -1, 0};
    vecs[4] = '{11'h100, 11'd2, 40'h0000004241, 0, 2};

    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_par_flip = 1'b0;
    msg_base = '0; msg_len = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_parity_err", parity_err, 0);
    reset = 1'b1;

    wr(11'h040, 8'h4D, 1'b0); wr(11'h041, 8'h65, 1'b0); wr(11'h042, 8'h72, 1'b0);
    wr(11'h043, 8'h72, 1'b0); wr(11'h044, 8'h79, 1'b0);
    wr(11'h7FE, 8'h57, 1'b0); wr(11'h7FF, 8'h58, 1'b0);
    wr(11'h000, 8'h59, 1'b0); wr(11'h001, 8'h5A, 1'b0);
    wr(11'h100, 8'h41, 1'b0); wr(11'h101, 8'h42, 1'b0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Looping message, aborted by stop.
    @(negedge clk);
    msg_base = 11'h100; msg_len = 11'd2; loop_en = 1'b1; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) repeat (2) @(negedge clk);
      @(negedge clk);
      check("loop_valid", out_valid, 1);
      check("loop_data", out_data, (k % 2 == 0) ? 32'h41 : 32'h42);
      check("loop_no_done", done, 0);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; loop_en = 1'b0;
    check("stop_valid", out_valid, 0);
    check("stop_busy", busy, 0);
    check("stop_no_done", done, 0);

    // Zero-length message.
    @(negedge clk);
    msg_len = 11'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0_done", done, 1);
    check("len0_valid", out_valid, 0);
    @(negedge clk);
    check("len0_done_clr", done, 0);
    check("len0_busy", busy, 0);
    check("len0_valid2", out_valid, 0);

    // stop wins over a simultaneous start.
    @(negedge clk);
    msg_base = 11'h040; msg_len = 11'd5; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("stop_start_busy", busy, 0);
    check("stop_start_done", done, 0);

    // Same-address write during FETCH reads old data.
    @(negedge clk);
    msg_base = 11'h100; msg_len = 11'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b1; wr_addr = 11'h100; wr_data = 8'h51;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check("rdfirst_valid", out_valid, 1);
    check("rdfirst_old", out_data, 8'h41);
    repeat (2) @(negedge clk);
    run_vec('{11'h100, 11'd1, 40'h51, -1, 0});

    // Parity fault injection.
    wr(11'h200, 8'h41, 1'b1);
    @(negedge clk);
    msg_base = 11'h200; msg_len = 11'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("par_char", out_data, 8'h41);
`ifdef CHAR_PARITY_EN
    check("par_err_set", parity_err, 1);
`else
    check("par_err_off", parity_err, 0);
`endif
    repeat (2) @(negedge clk);
`ifdef CHAR_PARITY_EN
    check("par_err_sticky", parity_err, 1);
`else
    check("par_err_off2", parity_err, 0);
`endif
    msg_len = 11'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("par_err_clr", parity_err, 0);
    @(negedge clk);

    // Asynchronous reset mid-message.
    @(negedge clk);
    msg_base = 11'h040; msg_len = 11'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_done", done, 0);
    check("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
